// File: rtl/run_dump_controller_pkg.sv
// run_dump_controller_pkg: shared types for the run/dump controller.
// Holds the controller state enum, dump_kind codes and index helpers.
package run_dump_controller_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_REG_RD,
        S_REG_OUT,
        S_MEM_RD,
        S_MEM_OUT,
        S_DONE
    } state_t;

    // dump_kind encoding on the dump stream
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Word index to byte address (word-aligned, 4 bytes per word)
    function automatic logic [31:0] word_to_byte(input logic [31:0] word);
        return {word[29:0], 2'b00};
    endfunction

    // Index width that never collapses to zero bits
    function automatic int safe_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// cycle_counter: loadable saturating down-counter with a zero flag.
// Ports: clk, reset (async, active high), load + load_value (load wins),
// enable (count down by one, never below zero), zero (count == 0).
module cycle_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/run_dump_controller.sv
// run_dump_controller: runs the CPU for a set number of cycles, then
// streams every register and data-memory word out over a valid/ready port.
// Ports:
//   clk, reset          - clock, async active-high reset
//   start, run_cycles   - session request and CPU cycle budget
//   cpu_en              - CPU clock enable (high only while running)
//   reg_addr / reg_rd   - register-file read port (combinational)
//   mem_addr / mem_rd   - data-memory byte address / read data
//   dump_valid/ready    - dump stream handshake
//   dump_kind/index/data- item payload (0 = register, 1 = memory)
//   busy, done          - session status
module run_dump_controller
    import run_dump_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int MEM_WORDS  = 64,
    parameter int CYCLE_W    = 16,
    localparam int RA_W      = safe_clog2(REG_COUNT),
    localparam int MA_W      = safe_clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CYCLE_W-1:0]    run_cycles,
    output logic                  cpu_en,
    output logic [RA_W-1:0]       reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_rd,
    output logic [31:0]           mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  dump_kind,
    output logic [31:0]           dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (RA_W > MA_W) ? RA_W : MA_W;

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

    state_t state;
    state_t state_next;

    logic [IDX_W-1:0]   idx;
    logic               start_ok;
    logic               reg_last;
    logic               mem_last;
    logic               cnt_load;
    logic               cnt_en;
    logic               cnt_zero;
    logic [CYCLE_W-1:0] cnt_load_value;

    assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
    assign reg_last = (idx == REG_LAST);
    assign mem_last = (idx == MEM_LAST);

    // The counter holds the cycles remaining after the current one, so a
    // budget of N loads N-1 and RUN ends on the cycle the count reads zero.
    // This keeps 2^CYCLE_W-1 representable without any wrap.
    assign cnt_load       = start_ok;
    assign cnt_load_value = (run_cycles == '0) ? '0
                                               : run_cycles - CYCLE_W'(1);
    assign cnt_en         = (state == S_RUN) && !cnt_zero;

    cycle_counter #(
        .W(CYCLE_W)
    ) u_cycle_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .load_value(cnt_load_value),
        .enable    (cnt_en),
        .zero      (cnt_zero)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = (run_cycles == '0) ? S_REG_RD : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_zero) begin
                    state_next = S_REG_RD;
                end
            end
            S_REG_RD: begin
                state_next = S_REG_OUT;
            end
            S_REG_OUT: begin
                if (dump_ready) begin
                    state_next = reg_last ? S_MEM_RD : S_REG_RD;
                end
            end
            S_MEM_RD: begin
                state_next = S_MEM_OUT;
            end
            S_MEM_OUT: begin
                if (dump_ready) begin
                    state_next = mem_last ? S_DONE : S_MEM_RD;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; cpu_en falls the moment reset hits
    always_comb begin
        cpu_en     = 1'b0;
        dump_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
            end
            S_RUN: begin
                cpu_en = 1'b1;
                busy   = 1'b1;
            end
            S_REG_RD, S_MEM_RD: begin
                busy = 1'b1;
            end
            S_REG_OUT, S_MEM_OUT: begin
                dump_valid = 1'b1;
                busy       = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Read ports always follow idx
    assign reg_addr = idx[RA_W-1:0];
    assign mem_addr = word_to_byte(32'(idx));

    // Index and payload registers; payload only changes in the RD states,
    // so it stays frozen while an item waits for dump_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            dump_kind  <= KIND_REG;
            dump_index <= '0;
            dump_data  <= '0;
        end else begin
            if (start_ok) begin
                idx <= '0;
            end
            unique case (state)
                S_REG_RD: begin
                    dump_kind  <= KIND_REG;
                    dump_index <= 32'(idx);
                    dump_data  <= reg_rd;
                end
                S_REG_OUT: begin
                    if (dump_ready) begin
                        idx <= reg_last ? '0 : idx + IDX_W'(1);
                    end
                end
                S_MEM_RD: begin
                    dump_kind  <= KIND_MEM;
                    dump_index <= word_to_byte(32'(idx));
                    dump_data  <= mem_rd;
                end
                S_MEM_OUT: begin
                    if (dump_ready) begin
                        idx <= mem_last ? '0 : idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_dump_controller.sv
// tb_run_dump_controller: directed self-checking bench for run_dump_controller.
// Models register file and memory as arrays and checks run length, stream order, stalls and reset.
module tb_run_dump_controller;
    import run_dump_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] run_cycles;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rd;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_kind;
    logic [31:0] dump_index;
    logic [31:0] dump_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    logic [31:0] mem  [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign reg_rd = regs[reg_addr];
    assign mem_rd = mem[mem_addr[7:2]];

    run_dump_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .run_cycles(run_cycles),
        .cpu_en    (cpu_en),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_kind (dump_kind),
        .dump_index(dump_index),
        .dump_data (dump_data),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill();
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
    endtask

    function automatic logic [64:0] exp_item(input int n);
        if (n < 32) return {KIND_REG, 32'(n), regs[n]};
        return {KIND_MEM, 32'((n - 32) * 4), mem[n - 32]};
    endfunction

    // Pulse start, then count cpu_en cycles until the first item shows up
    task automatic start_session(input logic [15:0] n, output int lat,
                                 output int en, output logic d0);
        run_cycles = n;
        start = 1'b1;
        step();
        start = 1'b0;
        run_cycles = 16'd7;
        d0 = done;
        lat = 0;
        en = 0;
        while (!dump_valid && lat < 70000) begin
            if (cpu_en) en++;
            step();
            lat++;
        end
    endtask

    // Consume the stream, optionally stalling one item for 10 cycles and
    // poking start once while busy.
    task automatic drain(input int stall_item, input int start_at,
                         output int cycles);
        int n;
        int stalls;
        int en_seen;
        n = 0;
        stalls = 0;
        en_seen = 0;
        cycles = 0;
        while (!done && cycles < 2000) begin
            start = (cycles == start_at);
            run_cycles = 16'd3;
            if (cpu_en) en_seen++;
            if (dump_valid) begin
                if (n < 96) begin
                    check($sformatf("item%0d", n),
                          128'({dump_kind, dump_index, dump_data}),
                          128'(exp_item(n)));
                end else begin
                    check("item_overflow", 128'(n), 128'(95));
                end
                if (n == stall_item && stalls < 10) begin
                    dump_ready = 1'b0;
                    stalls++;
                end else begin
                    dump_ready = 1'b1;
                    n++;
                end
            end
            step();
            cycles++;
        end
        start = 1'b0;
        check("item_count", 128'(n), 128'(96));
        check("cpu_en_in_dump", 128'(en_seen), 128'(0));
        check("done_high", 128'(done), 128'(1));
        check("busy_low_done", 128'(busy), 128'(0));
    endtask

    initial begin
        int   lat;
        int   en;
        int   cyc;
        int   bad;
        logic d0;

        reset = 1'b1;
        start = 1'b0;
        dump_ready = 1'b0;
        run_cycles = 16'd0;
        fill();
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_en", 128'(cpu_en), 128'(0));
        check("rst_valid", 128'(dump_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_kind", 128'(dump_kind), 128'(0));
        check("rst_index", 128'(dump_index), 128'(0));
        check("rst_data", 128'(dump_data), 128'(0));
        check("rst_reg_addr", 128'(reg_addr), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        reset = 1'b0;
        step();
        check("idle_busy", 128'(busy), 128'(0));

        // Run 5 cycles, hold first item, then full stream
        start_session(16'd5, lat, en, d0);
        check("a_en_cycles", 128'(en), 128'(5));
        check("a_latency", 128'(lat), 128'(6));
        check("a_first", 128'({dump_kind, dump_index, dump_data}),
              128'({KIND_REG, 32'd0, regs[0]}));
        repeat (3) step();
        check("a_hold", 128'({dump_valid, dump_kind, dump_index, dump_data}),
              128'({1'b1, KIND_REG, 32'd0, regs[0]}));
        drain(-1, -1, cyc);
        check("a_stream_cycles", 128'(cyc), 128'(191));

        // Restart from DONE with zero cycles; stall item 3; stray start
        fill();
        start_session(16'd0, lat, en, d0);
        check("b_done_clear", 128'(d0), 128'(0));
        check("b_en_cycles", 128'(en), 128'(0));
        check("b_latency", 128'(lat), 128'(1));
        drain(3, 20, cyc);
        check("b_stream_cycles", 128'(cyc), 128'(201));

        // Largest budget runs to completion with no wrap
        start_session(16'hFFFF, lat, en, d0);
        check("c_en_cycles", 128'(en), 128'(65535));
        check("c_latency", 128'(lat), 128'(65536));
        drain(-1, -1, cyc);
        check("c_stream_cycles", 128'(cyc), 128'(191));

        // Reset during cycle 3 of an 8-cycle run
        run_cycles = 16'd8;
        start = 1'b1;
        step();
        start = 1'b0;
        check("d_run_c1", 128'(cpu_en), 128'(1));
        step();
        step();
        check("d_run_c3", 128'(cpu_en), 128'(1));
        #2;
        reset = 1'b1;
        #1;
        check("d_rst_cpu_en", 128'(cpu_en), 128'(0));
        check("d_rst_busy", 128'(busy), 128'(0));
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cpu_en || dump_valid || busy || done || dump_kind ||
                dump_index != 0 || dump_data != 0 || reg_addr != 0 ||
                mem_addr != 0) bad++;
        end
        check("d_quiet", 128'(bad), 128'(0));

        // Fresh session after the abort
        fill();
        start_session(16'd2, lat, en, d0);
        check("e_en_cycles", 128'(en), 128'(2));
        check("e_latency", 128'(lat), 128'(3));
        drain(-1, -1, cyc);
        check("e_stream_cycles", 128'(cyc), 128'(191));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
